frame_rr_arbiter: RTL and testbench

FRAME_RR_ARBITER -- requirements
Module: frame_rr_arbiter

---
 rtl/frame_rr_arbiter_pkg.sv | 34 +++
 rtl/frame_rr_arbiter_rr_pick.sv | 36 +++
 rtl/frame_rr_arbiter.sv | 178 +++++++++++++++++
 tb/tb_frame_rr_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/frame_rr_arbiter_pkg.sv
// ============================================================================
// Module   : genericSwitchPkg
// Purpose  : Shared cell descriptor types, port count and arbiter FSM states.
// Revision : 1.0
// ============================================================================
`default_nettype none

package genericSwitchPkg;

    localparam int nbrOfPorts = 4;
    localparam int C_PORT_W   = $clog2(nbrOfPorts);

    typedef struct packed {
        logic startOfFrame;
        logic endOfFrame;
        logic error;
    } info_type;

    typedef struct packed {
        logic [C_PORT_W-1:0] port;
        logic [7:0]          address;
        logic [5:0]          length;
        logic                dataPresent;
        info_type            info;
    } cell_queue_type;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arbState_type;

endpackage

`default_nettype wire

// File: rtl/frame_rr_arbiter_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker: first eligible index at or
//            after the pointer, wrapping modulo the port count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NBR_PORTS = 4,
    parameter int IDX_W     = $clog2(NBR_PORTS)
) (
    input  logic [NBR_PORTS-1:0] i_eligible,
    input  logic [IDX_W-1:0]     i_rr_ptr,
    output logic [IDX_W-1:0]     o_winner,
    output logic                 o_found
);

    function automatic logic [IDX_W-1:0] f_wrap(input logic [IDX_W-1:0] ptr, input int ofs);
        f_wrap = IDX_W'((int'(ptr) + ofs) % NBR_PORTS);
    endfunction

    always_comb begin
        o_winner = '0;
        o_found  = 1'b0;
        for (int k = 0; k < NBR_PORTS; k++) begin
            if (!o_found && i_eligible[f_wrap(i_rr_ptr, k)]) begin
                o_found  = 1'b1;
                o_winner = f_wrap(i_rr_ptr, k);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/frame_rr_arbiter.sv
// ============================================================================
// Module   : frame_rr_arbiter
// Purpose  : Frame-aware round-robin arbiter with a registered output stage.
//            Optional idle-lock abort enabled by FRAME_LOCK_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module frame_rr_arbiter
    import genericSwitchPkg::*;
#(
    parameter int nbrOfPorts  = genericSwitchPkg::nbrOfPorts,
    parameter int lockTimeout = 256
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic           [nbrOfPorts-1:0]        req,
    input  cell_queue_type [nbrOfPorts-1:0]        reqCell,
    output logic           [nbrOfPorts-1:0]        ack,
    output logic                                   outValid,
    output cell_queue_type                         outCell,
    output logic           [$clog2(nbrOfPorts)-1:0] outPort,
    input  logic                                   outReady,
    output logic                                   timeoutPulse
);

    localparam int                    C_PW  = $clog2(nbrOfPorts);
    localparam logic [nbrOfPorts-1:0] C_ONE = nbrOfPorts'(1);

    arbState_type   r_state_q, w_state_d;
    logic [C_PW-1:0] r_rr_ptr_q, w_rr_ptr_d;
    logic [C_PW-1:0] r_lock_port_q, w_lock_port_d;
    logic           r_out_valid_q, w_out_valid_d;
    cell_queue_type r_out_cell_q, w_out_cell_d;
    logic [C_PW-1:0] r_out_port_q, w_out_port_d;

    logic [nbrOfPorts-1:0] w_eligible;
    logic [C_PW-1:0]       w_winner;
    logic                  w_found;
    logic                  w_load;
    cell_queue_type        w_sel_cell;
    logic                  w_timeout_pulse_d;

    function automatic logic [C_PW-1:0] f_next(input logic [C_PW-1:0] p);
        f_next = (int'(p) == nbrOfPorts - 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_eligible = req;
        if (r_state_q == LOCKED) begin
            w_eligible = req & (C_ONE << r_lock_port_q);
        end
    end

    rr_pick #(
        .NBR_PORTS (nbrOfPorts),
        .IDX_W     (C_PW)
    ) u_rr_pick (
        .i_eligible (w_eligible),
        .i_rr_ptr   (r_rr_ptr_q),
        .o_winner   (w_winner),
        .o_found    (w_found)
    );

    // Reset gates the load so no pop strobe escapes while rst is high.
    assign w_load     = !rst && w_found && (!r_out_valid_q || outReady);
    assign w_sel_cell = reqCell[w_winner];

    always_comb begin
        w_state_d     = r_state_q;
        w_rr_ptr_d    = r_rr_ptr_q;
        w_lock_port_d = r_lock_port_q;
        w_out_valid_d = r_out_valid_q;
        w_out_cell_d  = r_out_cell_q;
        w_out_port_d  = r_out_port_q;
        ack           = '0;

        if (w_load) begin
            ack           = C_ONE << w_winner;
            w_out_valid_d = 1'b1;
            w_out_cell_d  = w_sel_cell;
            w_out_port_d  = w_winner;
            case (r_state_q)
                IDLE: begin
                    if (!w_sel_cell.info.startOfFrame) begin
                        w_out_cell_d.info.error = 1'b1;
                        w_rr_ptr_d              = f_next(w_winner);
                    end else if (w_sel_cell.info.endOfFrame) begin
                        w_rr_ptr_d = f_next(w_winner);
                    end else begin
                        w_state_d     = LOCKED;
                        w_lock_port_d = w_winner;
                    end
                end
                LOCKED: begin
                    if (w_sel_cell.info.endOfFrame) begin
                        w_state_d  = IDLE;
                        w_rr_ptr_d = f_next(r_lock_port_q);
                    end else if (w_sel_cell.info.startOfFrame) begin
                        w_out_cell_d.info.error = 1'b1;
                    end
                end
                default: w_state_d = IDLE;
            endcase
        end else if (outReady) begin
            w_out_valid_d = 1'b0;
        end

        if (w_timeout_pulse_d) begin
            w_state_d  = IDLE;
            w_rr_ptr_d = f_next(r_lock_port_q);
        end
    end

`ifdef FRAME_LOCK_TIMEOUT_EN
    localparam int                 C_CNT_W    = $clog2(lockTimeout + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(lockTimeout - 1);

    logic [C_CNT_W-1:0] r_idle_cnt_q, w_idle_cnt_d;
    logic               r_timeout_pulse_q;

    // Counts load-free cycles while locked; any load or leaving LOCKED clears it.
    always_comb begin
        w_idle_cnt_d      = '0;
        w_timeout_pulse_d = 1'b0;
        if (r_state_q == LOCKED && !w_load) begin
            if (r_idle_cnt_q == C_CNT_LAST) begin
                w_timeout_pulse_d = 1'b1;
            end else begin
                w_idle_cnt_d = r_idle_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle_cnt_q      <= '0;
            r_timeout_pulse_q <= 1'b0;
        end else begin
            r_idle_cnt_q      <= w_idle_cnt_d;
            r_timeout_pulse_q <= w_timeout_pulse_d;
        end
    end

    assign timeoutPulse = r_timeout_pulse_q;
`else
    logic w_unused_cfg;

    assign w_unused_cfg      = |lockTimeout;
    assign w_timeout_pulse_d = 1'b0;
    assign timeoutPulse      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= IDLE;
            r_rr_ptr_q    <= '0;
            r_lock_port_q <= '0;
            r_out_valid_q <= 1'b0;
            r_out_cell_q  <= '0;
            r_out_port_q  <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_rr_ptr_q    <= w_rr_ptr_d;
            r_lock_port_q <= w_lock_port_d;
            r_out_valid_q <= w_out_valid_d;
            r_out_cell_q  <= w_out_cell_d;
            r_out_port_q  <= w_out_port_d;
        end
    end

    assign outValid = r_out_valid_q;
    assign outCell  = r_out_cell_q;
    assign outPort  = r_out_port_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_rr_arbiter.sv
// ============================================================================
// Module   : tb_frame_rr_arbiter
// Purpose  : Directed self-checking bench for frame_rr_arbiter (4 ports).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_frame_rr_arbiter;
    import genericSwitchPkg::*;

    localparam int N = 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic           [N-1:0]    req;
    cell_queue_type [N-1:0]    reqCell;
    logic           [N-1:0]    ack;
    logic                      outValid;
    cell_queue_type            outCell;
    logic           [1:0]      outPort;
    logic                      outReady;
    logic                      timeoutPulse;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    frame_rr_arbiter #(
        .nbrOfPorts  (N),
        .lockTimeout (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .reqCell      (reqCell),
        .ack          (ack),
        .outValid     (outValid),
        .outCell      (outCell),
        .outPort      (outPort),
        .outReady     (outReady),
        .timeoutPulse (timeoutPulse)
    );

    function automatic cell_queue_type mk(input logic sof, input logic eof, input logic [7:0] addr);
        mk                   = '0;
        mk.port              = addr[1:0];
        mk.address           = addr;
        mk.length            = 6'd4;
        mk.dataPresent       = 1'b1;
        mk.info.startOfFrame = sof;
        mk.info.endOfFrame   = eof;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        req      = 4'b1111;
        outReady = 1'b1;
        for (int i = 0; i < N; i++) reqCell[i] = mk(1'b1, 1'b1, 8'(16 * i + 1));
        #1;
        chk("rst_ack", 32'(ack), 32'h0);
        tick;
        chk("rst_valid", 32'(outValid), 32'h0);
        chk("rst_cell", 32'(outCell), 32'h0);
        chk("rst_port", 32'(outPort), 32'h0);
        chk("rst_tmo", 32'(timeoutPulse), 32'h0);

        // Single-cell frames from every port rotate 0,1,2,3,0.
        rst = 1'b0;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk("rr_ack", 32'(ack), 32'(1 << (s % 4)));
            tick;
            chk("rr_port", 32'(outPort), 32'(s % 4));
            chk("rr_addr", 32'(outCell.address), 32'(16 * (s % 4) + 1));
        end

        // Port 1 multi-cell frame while ports 0 and 2 contend.
        req = 4'b0111;
        for (int s = 0; s < 4; s++) begin
            reqCell[1] = mk(s == 0, s == 3, 8'(8'h40 + s));
            #1;
            chk("frm_ack", 32'(ack), 32'h2);
            tick;
            chk("frm_addr", 32'(outCell.address), 32'(8'h40 + s));
            chk("frm_err", 32'(outCell.info.error), 32'h0);
        end
        req = 4'b0101;
        #1;
        chk("frm_next_ack", 32'(ack), 32'h4);
        tick;
        chk("frm_next_port", 32'(outPort), 32'h2);

        // Backpressure holds the output stage.
        outReady = 1'b0;
        req      = 4'b0001;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("bp_ack", 32'(ack), 32'h0);
            tick;
            chk("bp_valid", 32'(outValid), 32'h1);
            chk("bp_addr", 32'(outCell.address), 32'h21);
            chk("bp_port", 32'(outPort), 32'h2);
        end
        outReady = 1'b1;
        #1;
        chk("bp_resume_ack", 32'(ack), 32'h1);
        tick;
        chk("bp_resume_port", 32'(outPort), 32'h0);

        // Orphan mid-frame cell in IDLE gets error and does not lock.
        req        = 4'b1000;
        reqCell[3] = mk(1'b0, 1'b0, 8'h33);
        #1;
        chk("orph_ack", 32'(ack), 32'h8);
        tick;
        chk("orph_err", 32'(outCell.info.error), 32'h1);
        chk("orph_port", 32'(outPort), 32'h3);
        chk("orph_addr", 32'(outCell.address), 32'h33);
        chk("orph_len", 32'(outCell.length), 32'h4);
        req = 4'b0011;
        #1;
        chk("orph_nolock_ack", 32'(ack), 32'h1);
        tick;

        // SOF while locked: error flagged, lock kept.
        req        = 4'b0010;
        reqCell[1] = mk(1'b1, 1'b0, 8'h50);
        #1;
        chk("relock_ack0", 32'(ack), 32'h2);
        tick;
        chk("relock_err0", 32'(outCell.info.error), 32'h0);
        reqCell[1] = mk(1'b1, 1'b0, 8'h51);
        #1;
        chk("relock_ack1", 32'(ack), 32'h2);
        tick;
        chk("relock_err1", 32'(outCell.info.error), 32'h1);
        req = 4'b0101;
        #1;
        chk("relock_wait_ack", 32'(ack), 32'h0);
        tick;
        chk("relock_wait_valid", 32'(outValid), 32'h0);
        req        = 4'b0111;
        reqCell[1] = mk(1'b0, 1'b1, 8'h52);
        #1;
        chk("relock_eof_ack", 32'(ack), 32'h2);
        tick;
        chk("relock_eof_err", 32'(outCell.info.error), 32'h0);

        // Reset while locked on port 2 drops the lock.
        req        = 4'b0100;
        reqCell[2] = mk(1'b1, 1'b0, 8'h60);
        #1;
        chk("lk2_ack", 32'(ack), 32'h4);
        tick;
        rst = 1'b1;
        req = 4'b0101;
        #1;
        chk("midrst_ack", 32'(ack), 32'h0);
        tick;
        chk("midrst_valid", 32'(outValid), 32'h0);
        chk("midrst_port", 32'(outPort), 32'h0);
        rst        = 1'b0;
        reqCell[0] = mk(1'b1, 1'b1, 8'h02);
        reqCell[2] = mk(1'b1, 1'b1, 8'h62);
        #1;
        chk("postrst_ack0", 32'(ack), 32'h1);
        tick;
        #1;
        chk("postrst_ack2", 32'(ack), 32'h4);
        tick;
        chk("postrst_err", 32'(outCell.info.error), 32'h0);
        chk("postrst_addr", 32'(outCell.address), 32'h62);

        // Lock on port 0, then port 0 goes quiet while port 1 waits.
        req        = 4'b0001;
        reqCell[0] = mk(1'b1, 1'b0, 8'h70);
        #1;
        chk("tmo_lock_ack", 32'(ack), 32'h1);
        tick;
        req        = 4'b0010;
        reqCell[1] = mk(1'b1, 1'b1, 8'h12);
`ifdef FRAME_LOCK_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("tmo_wait_ack", 32'(ack), 32'h0);
            tick;
            chk("tmo_pulse", 32'(timeoutPulse), 32'(i == 7));
        end
        #1;
        chk("tmo_grant_ack", 32'(ack), 32'h2);
        tick;
        chk("tmo_grant_port", 32'(outPort), 32'h1);
        chk("tmo_pulse_end", 32'(timeoutPulse), 32'h0);
`else
        for (int i = 0; i < 12; i++) begin
            #1;
            chk("hold_ack", 32'(ack), 32'h0);
            tick;
            chk("hold_tmo", 32'(timeoutPulse), 32'h0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
